// File: rtl/br_pkg.sv
// br_pkg: shared constants and types for the register-bank issue sequencer.
//   Control word layout {OP[19:15], AR2[14:10], AR1[9:5], AW[4:0]}, the opcode
//   encodings, the FSM state type and small opcode-classification helpers.
package br_pkg;

   localparam int WORD_W  = 20;
   localparam int FIELD_W = 5;
   localparam int OP_LSB  = 15;
   localparam int AR2_LSB = 10;
   localparam int AR1_LSB = 5;
   localparam int AW_LSB  = 0;

   localparam logic [FIELD_W-1:0] OP_NOP  = 5'b00000;
   localparam logic [FIELD_W-1:0] OP_ADD  = 5'b00001;
   localparam logic [FIELD_W-1:0] OP_AND  = 5'b00010;
   localparam logic [FIELD_W-1:0] OP_CMP  = 5'b00100;
   localparam logic [FIELD_W-1:0] OP_HALT = 5'b11111;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      ISSUE  = 3'd2,
      BUBBLE = 3'd3,
      HALTED = 3'd4
   } state_t;

   // Opcodes that may be placed on the bus (HALT is consumed by the sequencer).
   function automatic logic op_issuable(input logic [FIELD_W-1:0] op);
      return (op == OP_NOP) || (op == OP_ADD) || (op == OP_AND) || (op == OP_CMP);
   endfunction

   // Opcodes that write the register bank through AW.
   function automatic logic op_writes(input logic [FIELD_W-1:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_CMP);
   endfunction

endpackage

// File: rtl/br_prog_mem.sv
// br_prog_mem: 2**PC_W x WORD_W program RAM, one write port, one synchronous
//   read port. A read and write to the same address in one cycle returns the
//   new data, so a program word written together with start is fetched.
// Ports:
//   clk    in   clock
//   we     in   write strobe
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (sampled on the rising edge)
//   rdata  out  registered read data
module br_prog_mem
   import br_pkg::*;
#(
   parameter int PC_W = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PC_W-1:0]   waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [PC_W-1:0]   raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [2**PC_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
   end

endmodule

// File: rtl/br_issue_seq.sv
// br_issue_seq: instruction sequencer for the register-bank/ALU control bus.
//   Fetches words from br_prog_mem starting at start_addr and issues one word
//   per valid/ready handshake; stops on HALT, an undefined opcode or the last
//   memory address (pc never wraps).
// Optional feature macro: HAZARD_STALL_EN -- adds a one-cycle BUBBLE before a
//   word whose AR1/AR2 matches the AW of the last handshaken ADD/AND/CMP.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   prog_we/addr/data      program load port, honoured only while idle
//   start, start_addr      begin execution (ignored while busy)
//   bus_ready              consumer handshake
//   control_bus, bus_valid issued word (zero when not valid)
//   pc                     address of the word being fetched/issued
//   busy, done, illegal_op status; done/illegal_op are sticky until start/rst
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | read data for pc available, decode it
// BUBBLE | one-cycle hazard stall before ISSUE (HAZARD_STALL_EN only)
// ISSUE  | word on the bus, waiting for bus_ready
// HALTED | program ended, waiting for start
module br_issue_seq
   import br_pkg::*;
#(
   parameter int PC_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_we,
   input  logic [PC_W-1:0]   prog_addr,
   input  logic [WORD_W-1:0] prog_data,
   input  logic              start,
   input  logic [PC_W-1:0]   start_addr,
   input  logic              bus_ready,
   output logic [WORD_W-1:0] control_bus,
   output logic              bus_valid,
   output logic [PC_W-1:0]   pc,
   output logic              busy,
   output logic              done,
   output logic              illegal_op
);

   localparam logic [PC_W-1:0] PC_MAX = '1;

   state_t            state;
   logic [PC_W-1:0]   rd_addr;
   logic [WORD_W-1:0] rdata;
   logic [FIELD_W-1:0] rd_op;
   logic              idle_like;
   logic              start_go;
   logic              handshake;
   logic              hazard;

   assign idle_like = (state == IDLE) || (state == HALTED);
   assign start_go  = idle_like && start;
   assign handshake = (state == ISSUE) && bus_ready;
   assign rd_op     = rdata[OP_LSB +: FIELD_W];

   // Read address runs one step ahead of pc so the word is ready in FETCH.
   always_comb begin
      rd_addr = pc;
      if (start_go)
         rd_addr = start_addr;
      else if (handshake && (pc != PC_MAX))
         rd_addr = pc + 1'b1;
   end

   br_prog_mem #(.PC_W(PC_W)) u_mem (
      .clk   (clk),
      .we    (prog_we && idle_like),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (rd_addr),
      .rdata (rdata)
   );

`ifdef HAZARD_STALL_EN
   logic               trk_vld;
   logic [FIELD_W-1:0] trk_aw;
   logic               to_halted;

   assign to_halted = ((state == FETCH) && !op_issuable(rd_op))
                    || (handshake && (pc == PC_MAX));
   assign hazard = trk_vld && ((rdata[AR1_LSB +: FIELD_W] == trk_aw)
                            || (rdata[AR2_LSB +: FIELD_W] == trk_aw));

   always_ff @(posedge clk) begin
      if (rst) begin
         trk_vld <= 1'b0;
         trk_aw  <= '0;
      end else if (start_go || to_halted) begin
         trk_vld <= 1'b0;
      end else if (handshake && op_writes(control_bus[OP_LSB +: FIELD_W])) begin
         trk_vld <= 1'b1;
         trk_aw  <= control_bus[AW_LSB +: FIELD_W];
      end
   end
`else
   assign hazard = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= '0;
         control_bus <= '0;
         bus_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         illegal_op  <= 1'b0;
      end else begin
         case (state)
            IDLE, HALTED: begin
               if (start) begin
                  state      <= FETCH;
                  pc         <= start_addr;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  illegal_op <= 1'b0;
               end
            end
            FETCH: begin
               if (rd_op == OP_HALT) begin
                  state <= HALTED;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (!op_issuable(rd_op)) begin
                  state      <= HALTED;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  illegal_op <= 1'b1;
               end else if (hazard) begin
                  state <= BUBBLE;
               end else begin
                  state       <= ISSUE;
                  bus_valid   <= 1'b1;
                  control_bus <= rdata;
               end
            end
`ifdef HAZARD_STALL_EN
            BUBBLE: begin
               state       <= ISSUE;
               bus_valid   <= 1'b1;
               control_bus <= rdata;
            end
`endif
            ISSUE: begin
               if (bus_ready) begin
                  bus_valid   <= 1'b0;
                  control_bus <= '0;
                  if (pc == PC_MAX) begin
                     state <= HALTED;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= FETCH;
                     pc    <= pc + 1'b1;
                  end
               end
            end
            default: begin
               state       <= IDLE;
               bus_valid   <= 1'b0;
               control_bus <= '0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_br_issue_seq.sv
// tb_br_issue_seq: randomized self-checking bench for br_issue_seq. A program
//   model walks the bench's copy of program memory to predict the issued words,
//   their addresses, stall bubbles, the end reason and the final pc; the
//   monitor checks ordering, handshake timing and bus stability cycle by cycle.
module tb_br_issue_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        prog_we;
   logic [4:0]  prog_addr;
   logic [19:0] prog_data;
   logic        start;
   logic [4:0]  start_addr;
   logic        bus_ready;
   logic [19:0] control_bus;
   logic        bus_valid;
   logic [4:0]  pc;
   logic        busy;
   logic        done;
   logic        illegal_op;

   int n_cmp = 0;
   int n_err = 0;

   logic [19:0] mem_m [32];
   logic [19:0] exp_w [$];
   logic [4:0]  exp_a [$];
   bit          exp_b [$];

   always #5 clk = ~clk;

   br_issue_seq #(.PC_W(5)) dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .start_addr(start_addr),
      .bus_ready(bus_ready), .control_bus(control_bus), .bus_valid(bus_valid),
      .pc(pc), .busy(busy), .done(done), .illegal_op(illegal_op)
   );

   function automatic bit legal(input logic [4:0] op);
      return op inside {5'b00000, 5'b00001, 5'b00010, 5'b00100};
   endfunction

   task automatic load(input logic [4:0] a, input logic [19:0] d);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      mem_m[a] = d;
   endtask

   // rmode: 0 ready always, 1 random ready plus ignored start/write noise,
   //        2 ready low for 3 cycles on the second word.
   task automatic run_prog(input logic [4:0] sa, input int rmode, input bit sw,
                           input logic [4:0] swa, input logic [19:0] swd, input string nm);
      logic [19:0] w;
      logic [4:0]  a;
      logic [4:0]  end_pc;
      int          end_kind;
      int          idx, t_next, t_hs, stalls, exp_done;
      bit          held, seen_done, rdy;
      logic [19:0] hold_w;
      logic [4:0]  hold_pc;
`ifdef HAZARD_STALL_EN
      bit          tv;
      logic [4:0]  taw;
      tv = 0; taw = '0;
`endif
      if (sw) mem_m[swa] = swd;
      exp_w.delete(); exp_a.delete(); exp_b.delete();
      a = sa; end_kind = 2; end_pc = 5'd31;
      for (int k = 0; k < 32; k++) begin
         w = mem_m[a];
         if (w[19:15] == 5'b11111) begin end_kind = 0; end_pc = a; break; end
         if (!legal(w[19:15]))     begin end_kind = 1; end_pc = a; break; end
         exp_w.push_back(w);
         exp_a.push_back(a);
`ifdef HAZARD_STALL_EN
         exp_b.push_back(tv && (w[9:5] == taw || w[14:10] == taw));
         if (w[19:15] inside {5'b00001, 5'b00010, 5'b00100}) begin tv = 1; taw = w[4:0]; end
`else
         exp_b.push_back(1'b0);
`endif
         if (a == 5'd31) begin end_kind = 2; end_pc = a; break; end
         a = a + 5'd1;
      end

      @(negedge clk);
      start = 1'b1; start_addr = sa; bus_ready = 1'b1;
      prog_we = sw; prog_addr = swa; prog_data = swd;
      idx = 0; t_next = 2; t_hs = 0; held = 0; seen_done = 0; stalls = 0;
      hold_w = '0; hold_pc = '0;
      for (int cyc = 1; cyc <= 600; cyc++) begin
         @(negedge clk);
         start = 1'b0; prog_we = 1'b0;
         if (done) begin
            seen_done = 1;
            exp_done = t_hs + ((end_kind == 2) ? 1 : 2);
            n_cmp++;
            if (cyc !== exp_done) begin
               n_err++;
               $display("FAIL %s done_time: got cycle %0d, expected %0d", nm, cyc, exp_done);
            end
            break;
         end
         n_cmp++;
         if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy: got %b, expected 1 at cycle %0d", nm, busy, cyc);
         end
         if (bus_valid) begin
            n_cmp++;
            if (idx >= exp_w.size()) begin
               n_err++;
               $display("FAIL %s extra_word: got %h at pc %0d, expected none", nm, control_bus, pc);
            end else if (!held) begin
               if (cyc !== t_next || control_bus !== exp_w[idx] || pc !== exp_a[idx]) begin
                  n_err++;
                  $display("FAIL %s word%0d: got cyc=%0d bus=%h pc=%0d, expected cyc=%0d bus=%h pc=%0d",
                           nm, idx, cyc, control_bus, pc, t_next, exp_w[idx], exp_a[idx]);
               end
            end else if (control_bus !== hold_w || pc !== hold_pc) begin
               n_err++;
               $display("FAIL %s hold: got bus=%h pc=%0d, expected bus=%h pc=%0d",
                        nm, control_bus, pc, hold_w, hold_pc);
            end
            case (rmode)
               0: rdy = 1'b1;
               1: rdy = ($urandom_range(0, 2) != 0);
               default: begin
                  rdy = !(idx == 1 && stalls < 3);
                  if (!rdy) stalls++;
               end
            endcase
            bus_ready = rdy; hold_w = control_bus; hold_pc = pc;
            if (rdy) begin
               t_hs = cyc; idx++; held = 0;
               t_next = cyc + 2 + ((idx < exp_w.size()) ? int'(exp_b[idx]) : 0);
            end else begin
               held = 1;
            end
         end else begin
            n_cmp++;
            if (control_bus !== 20'h0 || held) begin
               n_err++;
               $display("FAIL %s idle_bus: got bus=%h valid=0 held=%0d, expected bus=00000 and no drop",
                        nm, control_bus, held);
            end
            bus_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (rmode == 1 && $urandom_range(0, 7) == 0) begin
            start = 1'b1; start_addr = 5'($urandom);
         end
         if (rmode == 1 && $urandom_range(0, 7) == 0) begin
            prog_we = 1'b1; prog_addr = 5'($urandom); prog_data = 20'($urandom);
         end
      end
      n_cmp++;
      if (!seen_done || idx !== exp_w.size() || illegal_op !== (end_kind == 1) ||
          pc !== end_pc || busy !== 1'b0 || bus_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s end: got done=%0d words=%0d ill=%b pc=%0d busy=%b valid=%b, expected done=1 words=%0d ill=%0d pc=%0d busy=0 valid=0",
                  nm, seen_done, idx, illegal_op, pc, busy, bus_valid,
                  exp_w.size(), (end_kind == 1), end_pc);
      end
      bus_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (control_bus !== 20'h0 || bus_valid !== 1'b0 || pc !== 5'd0 ||
          busy !== 1'b0 || done !== 1'b0 || illegal_op !== 1'b0) begin
         n_err++;
         $display("FAIL reset: got bus=%h v=%b pc=%0d busy=%b done=%b ill=%b, expected all 0",
                  control_bus, bus_valid, pc, busy, done, illegal_op);
      end
      rst = 1'b0;
   endtask

   task automatic load_basic();
      load(5'd0, 20'h08027); load(5'd1, 20'h09041); load(5'd2, 20'h10862);
      load(5'd3, 20'h20464); load(5'd4, 20'hF8000);
   endtask

   task automatic test_basic();
      load_basic();
      run_prog(5'd0, 0, 0, 5'd0, 20'h0, "basic");
   endtask

   task automatic test_stall();
      run_prog(5'd0, 2, 0, 5'd0, 20'h0, "stall");
   endtask

   task automatic test_illegal();
      load(5'd2, 20'h40000);
      run_prog(5'd0, 0, 0, 5'd0, 20'h0, "illegal");
   endtask

   task automatic test_end_of_mem();
      load(5'd30, 20'h08027); load(5'd31, 20'h09041);
      run_prog(5'd30, 0, 0, 5'd0, 20'h0, "end_of_mem");
   endtask

   task automatic test_reset_mid();
      bit got;
      load_basic();
      @(negedge clk);
      prog_we = 1'b0; start = 1'b1; start_addr = 5'd0; bus_ready = 1'b0;
      got = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (bus_valid) begin got = 1; break; end
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL rst_mid wait: got no bus_valid in 10 cycles, expected one");
      end
      prog_we = 1'b1; prog_addr = 5'd1; prog_data = 20'hF8000;
      @(negedge clk);
      prog_we = 1'b0; rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (control_bus !== 20'h0 || bus_valid !== 1'b0 || pc !== 5'd0 ||
          busy !== 1'b0 || done !== 1'b0 || illegal_op !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid: got bus=%h v=%b pc=%0d busy=%b done=%b ill=%b, expected all 0",
                  control_bus, bus_valid, pc, busy, done, illegal_op);
      end
      rst = 1'b0;
      run_prog(5'd0, 0, 0, 5'd0, 20'h0, "rerun");
   endtask

   task automatic test_write_start();
      load(5'd5, 20'hF8000); load(5'd6, 20'hF8000);
      run_prog(5'd5, 0, 1, 5'd5, 20'h10862, "write_start");
   endtask

   task automatic test_hazard();
      load(5'd0, 20'h08027); load(5'd1, 20'h000E2); load(5'd2, 20'hF8000);
      run_prog(5'd0, 0, 0, 5'd0, 20'h0, "hazard");
   endtask

   task automatic test_random();
      logic [4:0] op;
      int r;
      for (int it = 0; it < 6; it++) begin
         for (int a = 0; a < 32; a++) begin
            r = $urandom_range(0, 24);
            if (r == 0) op = 5'b11111;
            else if (r == 1) begin
               op = 5'b01000;
               for (int k = 0; k < 8; k++) begin
                  op = 5'($urandom);
                  if (!legal(op) && op != 5'b11111) break;
                  op = 5'b01000;
               end
            end else begin
               case ($urandom_range(0, 3))
                  0: op = 5'b00000;
                  1: op = 5'b00001;
                  2: op = 5'b00010;
                  default: op = 5'b00100;
               endcase
            end
            load(5'(a), {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3))});
         end
         run_prog(5'($urandom), 1, 0, 5'd0, 20'h0, "random");
         run_prog(5'($urandom), 0, 0, 5'd0, 20'h0, "random_rdy");
      end
   endtask

   initial begin
      rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      start = 1'b0; start_addr = '0; bus_ready = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_illegal();
      test_end_of_mem();
      test_reset_mid();
      test_write_start();
      test_hazard();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
